// File: rtl/systolic_input_collector.sv
// Input-side collector for the systolic MAC array: packs BEATS narrow beats into one operand
// vector, pulses start_mult, then holds off upstream until done. Option: SYSTOLIC_IN_PARITY_EN.
module systolic_input_collector #(
    parameter  int IN_WIDTH  = 64,
    parameter  int OUT_WIDTH = 512,
    localparam int BEATS     = OUT_WIDTH / IN_WIDTH,
    localparam int CW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [IN_WIDTH-1:0]  data_in,
`ifdef SYSTOLIC_IN_PARITY_EN
    input  logic                 data_in_par,
    output logic                 par_err,
`endif
    input  logic                 done_matrix_mult,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 start_mult,
    output logic                 busy,
    output logic [CW-1:0]        beat_count
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   src_ready_r;
    logic                   src_ready_s;
    logic                   busy_r;
    logic                   busy_s;
    logic                   start_r;
    logic                   start_s;
    logic [CW-1:0]          beat_count_r;
    logic [OUT_WIDTH-1:0]   pack_r;
    logic [OUT_WIDTH-1:0]   pack_s;
    logic [OUT_WIDTH-1:0]   data_out_r;
    logic                   accept_s;
    logic                   last_beat_s;

    assign accept_s    = src_valid && src_ready_r;
    assign last_beat_s = (beat_count_r == CW'(BEATS - 1));

    assign src_ready  = src_ready_r;
    assign busy       = busy_r;
    assign start_mult = start_r;
    assign beat_count = beat_count_r;
    assign data_out   = data_out_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; done is only observed while waiting
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if (accept_s && last_beat_s) state_s = ST_ISSUE;
                else                         state_s = ST_COLLECT;
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (done_matrix_mult) state_s = ST_COLLECT;
                else                  state_s = ST_WAIT;
            end
            default: state_s = ST_COLLECT;
        endcase
    end

    // Output decode from the next state so the handshake outputs come straight from flops
    always_comb begin
        src_ready_s = 1'b0;
        busy_s      = 1'b0;
        start_s     = 1'b0;
        case (state_s)
            ST_COLLECT: src_ready_s = 1'b1;
            ST_ISSUE: begin
                busy_s  = 1'b1;
                start_s = 1'b1;
            end
            ST_WAIT:  busy_s = 1'b1;
            default:  src_ready_s = 1'b1;
        endcase
    end

    // Registered handshake/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            start_r     <= 1'b0;
        end else begin
            src_ready_r <= src_ready_s;
            busy_r      <= busy_s;
            start_r     <= start_s;
        end
    end

    // Pack image with the incoming beat dropped into its slot
    always_comb begin
        pack_s = pack_r;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_count_r == CW'(k)) pack_s[k*IN_WIDTH +: IN_WIDTH] = data_in;
            else                        pack_s[k*IN_WIDTH +: IN_WIDTH] = pack_r[k*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Beat packing; data_out is only reloaded on completion so refill cannot disturb the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_r       <= '0;
            data_out_r   <= '0;
            beat_count_r <= '0;
        end else if (accept_s) begin
            pack_r <= pack_s;
            if (last_beat_s) begin
                data_out_r   <= pack_s;
                beat_count_r <= '0;
            end else begin
                beat_count_r <= beat_count_r + CW'(1);
            end
        end else begin
            pack_r       <= pack_r;
            data_out_r   <= data_out_r;
            beat_count_r <= beat_count_r;
        end
    end

`ifdef SYSTOLIC_IN_PARITY_EN
    logic par_err_r;

    function automatic logic parity_bad(input logic [IN_WIDTH-1:0] d, input logic p);
        return ^{d, p};
    endfunction

    assign par_err = par_err_r;

    // Sticky parity flag; the beat is still used, only flagged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_err_r <= 1'b0;
        end else if (accept_s && parity_bad(data_in, data_in_par)) begin
            par_err_r <= 1'b1;
        end else begin
            par_err_r <= par_err_r;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_input_collector.sv
// Randomised bench for systolic_input_collector against a queue-based reference model.
module tb_systolic_input_collector;
    localparam int IW = 64;
    localparam int OW = 512;
    localparam int NB = OW / IW;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_valid;
    logic          src_ready;
    logic [IW-1:0] data_in;
    logic          done_matrix_mult;
    logic [OW-1:0] data_out;
    logic          start_mult;
    logic          busy;
    logic [2:0]    beat_count;
`ifdef SYSTOLIC_IN_PARITY_EN
    logic          data_in_par;
    logic          par_err;
    logic          m_par_err;
`endif

    int ncmp = 0;
    int nerr = 0;

    // Reference model: beats gathered so far, last issued vector, and run phase flags
    logic [IW-1:0] m_q[$];
    logic [OW-1:0] m_out;
    logic          m_issue;
    logic          m_wait;
    int            m_starts;

    systolic_input_collector dut (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
        .data_in(data_in),
`ifdef SYSTOLIC_IN_PARITY_EN
        .data_in_par(data_in_par), .par_err(par_err),
`endif
        .done_matrix_mult(done_matrix_mult), .data_out(data_out),
        .start_mult(start_mult), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check_eq("src_ready", OW'(src_ready), OW'(!m_issue && !m_wait));
        check_eq("busy", OW'(busy), OW'(m_issue || m_wait));
        check_eq("start_mult", OW'(start_mult), OW'(m_issue));
        check_eq("beat_count", OW'(beat_count), OW'(m_q.size()));
        check_eq("data_out", data_out, m_out);
`ifdef SYSTOLIC_IN_PARITY_EN
        check_eq("par_err", OW'(par_err), OW'(m_par_err));
`endif
    endtask

    task automatic model_clear();
        m_q.delete();
        m_out   = '0;
        m_issue = 1'b0;
        m_wait  = 1'b0;
`ifdef SYSTOLIC_IN_PARITY_EN
        m_par_err = 1'b0;
`endif
    endtask

    // One clock: drive at negedge, advance the model, check at the following negedge
    task automatic cycle(input logic v, input logic [IW-1:0] d, input logic dn, input logic bad_par);
        logic ready;
        src_valid        = v;
        data_in          = d;
        done_matrix_mult = dn;
`ifdef SYSTOLIC_IN_PARITY_EN
        data_in_par      = (^d) ^ bad_par;
`endif
        ready = !m_issue && !m_wait;
        if (m_issue) begin
            m_issue = 1'b0;
            m_wait  = 1'b1;
        end else if (m_wait) begin
            if (dn) m_wait = 1'b0;
        end else if (v && ready) begin
`ifdef SYSTOLIC_IN_PARITY_EN
            if (bad_par) m_par_err = 1'b1;
`endif
            m_q.push_back(d);
            if (m_q.size() == NB) begin
                for (int i = 0; i < NB; i++) m_out[i*IW +: IW] = m_q[i];
                m_q.delete();
                m_issue = 1'b1;
                m_starts++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        check_all();
    endtask

    function automatic logic [IW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [OW-1:0] snap;
        reset = 1'b0; src_valid = 1'b0; data_in = '0; done_matrix_mult = 1'b0;
`ifdef SYSTOLIC_IN_PARITY_EN
        data_in_par = 1'b0;
`endif
        m_starts = 0;
        model_clear();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Back-to-back beats 0..7, then linger in WAIT
        for (int i = 0; i < NB; i++) cycle(1'b1, IW'(i), 1'b0, 1'b0);
        check_eq("t1_start", OW'(start_mult), OW'(1));
        check_eq("t1_lo", OW'(data_out[63:0]), OW'(0));
        check_eq("t1_hi", OW'(data_out[511:448]), OW'(7));
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        snap = data_out;
        cycle(1'b0, '0, 1'b1, 1'b0);
        check_eq("t2_ready", OW'(src_ready), OW'(1));
        check_eq("t2_hold", data_out, snap);

        // Done pulse during ISSUE is ignored
        for (int i = 0; i < NB; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_eq("t2_busy", OW'(busy), OW'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Valid toggling every cycle
        for (int i = 0; i < 2 * NB; i++) cycle(i[0] == 1'b0, IW'(64'hA0 + i / 2), 1'b0, 1'b0);
        check_eq("t3_lo", OW'(data_out[63:0]), OW'(64'hA0));
        check_eq("t3_hi", OW'(data_out[511:448]), OW'(64'hA7));

        // Upstream pushing throughout WAIT
        for (int i = 0; i < 20; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Abort after 5 beats, then a clean vector
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        apply_reset();
        for (int i = 0; i < NB; i++) cycle(1'b1, IW'(64'hB0 + i), 1'b0, 1'b0);
        check_eq("t5_hi", OW'(data_out[511:448]), OW'(64'hB7));
        cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef SYSTOLIC_IN_PARITY_EN
        for (int i = 0; i < NB; i++) cycle(1'b1, rnd64(), 1'b0, i == 3);
        check_eq("t6_start", OW'(start_mult), OW'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < NB; i++) cycle(1'b1, rnd64(), 1'b0, 1'b0);
        check_eq("t6_sticky", OW'(par_err), OW'(1));
        apply_reset();
`endif

        // Random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset();
            else cycle($urandom_range(0, 9) < 7, rnd64(), $urandom_range(0, 4) == 0,
                       $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
